tcdm_bank_arbiter: RTL and testbench

//  Shares one single-port 32-bit SRAM bank (tc_sram, 1-cycle read latency) between NumReq TCDM masters
//  (e.g. the axi2tcdm ports). Round-robin grant, one access per cycle, response routed back to the owner.

---
 rtl/tcdm_bank_arb_pkg.sv | 28 ++
 rtl/tcdm_rr_picker.sv | 40 ++++
 rtl/tcdm_bank_arbiter.sv | 129 ++++++++++++
 tb/tb_tcdm_bank_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_bank_arb_pkg.sv
// rtl/tcdm_bank_arb_pkg.sv - shared types and helpers for the TCDM single-bank arbiter
package tcdm_bank_arb_pkg;

    // Byte-address bits below the word boundary of a 32-bit bank
    localparam int ADDR_LSB = 2;

    // Requester index storage; sized for the largest supported requester count
    localparam int MAX_REQ = 256;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef logic [IDX_W-1:0] idx_t;

    // One in-flight bank access awaiting its response slot
    typedef struct packed {
        logic vld;
        idx_t idx;
        logic is_read;
    } resp_t;

    // Increment an index modulo the requester count
    function automatic idx_t wrap_inc(input idx_t v, input int unsigned n);
        if (int'(v) + 1 >= int'(n)) begin
            return '0;
        end
        return v + idx_t'(1);
    endfunction

endpackage

// File: rtl/tcdm_rr_picker.sv
// rtl/tcdm_rr_picker.sv - combinational round-robin leading-one search with wrap
module tcdm_rr_picker
    import tcdm_bank_arb_pkg::*;
#(
    parameter int NumReq = 4
) (
    input  logic [NumReq-1:0] req_i,
    input  idx_t              ptr_i,
    output idx_t              idx_o,
    output logic              valid_o
);

    logic [2*NumReq-1:0] dbl;
    logic [2*NumReq-1:0] dbl_shift;
    logic [NumReq-1:0]   rot;
    logic                unused_hi;
    int                  sum;

    // Rotate the request vector so the pointer sits at bit 0, then take the first set bit
    always_comb begin
        dbl       = {req_i, req_i};
        dbl_shift = dbl >> ptr_i;
        rot       = dbl_shift[NumReq-1:0];
        unused_hi = ^dbl_shift[2*NumReq-1:NumReq];
        valid_o   = 1'b0;
        idx_o     = '0;
        sum       = 0;
        for (int off = 0; off < NumReq; off++) begin
            if (!valid_o && rot[off]) begin
                valid_o = 1'b1;
                sum     = int'(ptr_i) + off;
                if (sum >= NumReq) begin
                    sum = sum - NumReq;
                end
                idx_o = idx_t'(sum);
            end
        end
    end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// rtl/tcdm_bank_arbiter.sv - round-robin share of one SRAM bank among TCDM masters; optional TCDM_BANK_ARB_PERF_EN conflict counter
module tcdm_bank_arbiter
    import tcdm_bank_arb_pkg::*;
#(
    parameter int NumReq      = 4,
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int BankAddrW   = 10,
    parameter int WriteRespOn = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumReq-1:0]                     req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]      add_i,
    input  logic [NumReq-1:0]                     wen_i,
    input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]    be_i,
    output logic [NumReq-1:0]                     gnt_o,
    output logic [NumReq-1:0]                     vld_o,
    output logic [NumReq-1:0][DataWidth-1:0]      rdata_o,
    output logic                                  mem_req_o,
    output logic                                  mem_we_o,
    output logic [BankAddrW-1:0]                  mem_addr_o,
    output logic [DataWidth-1:0]                  mem_wdata_o,
    output logic [DataWidth/8-1:0]                mem_be_o,
    input  logic [DataWidth-1:0]                  mem_rdata_i,
    output logic [31:0]                           perf_conf_o
);

    localparam int IdxW = $clog2(NumReq);

    idx_t               rr_ptr_q;
    idx_t               win_idx;
    logic               win_vld;
    logic [IdxW-1:0]    win_sel;
    logic [AddrWidth-1:0] win_addr;
    resp_t              resp_d;
    resp_t              resp_q;
    logic [IdxW-1:0]    resp_sel;
    logic               unused_bits;

    tcdm_rr_picker #(
        .NumReq (NumReq)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (win_idx),
        .valid_o (win_vld)
    );

    assign win_sel  = win_idx[IdxW-1:0];
    assign resp_sel = resp_q.idx[IdxW-1:0];

    // Address bits outside the bank word range are deliberately dropped
    assign unused_bits = ^{win_addr, win_idx, resp_q.idx};

    // Grant and bank request mux: winner drives the bank, idle bank sees all zeros
    always_comb begin
        gnt_o       = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        win_addr    = add_i[win_sel];
        if (win_vld) begin
            gnt_o[win_sel] = 1'b1;
            mem_req_o      = 1'b1;
            mem_we_o       = ~wen_i[win_sel];
            mem_addr_o     = win_addr[ADDR_LSB +: BankAddrW];
            mem_wdata_o    = wdata_i[win_sel];
            mem_be_o       = be_i[win_sel];
        end
    end

    // Response slot for the access granted this cycle
    always_comb begin
        resp_d         = '0;
        resp_d.vld     = win_vld & (wen_i[win_sel] | (WriteRespOn != 0));
        resp_d.idx     = win_idx;
        resp_d.is_read = win_vld & wen_i[win_sel];
    end

    // Round-robin pointer and response register; reset discards any pending response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            resp_q   <= '0;
        end else begin
            if (win_vld) begin
                rr_ptr_q <= wrap_inc(win_idx, NumReq);
            end
            resp_q <= resp_d;
        end
    end

    // Route the bank response to the lane of the master that owns it
    always_comb begin
        vld_o   = '0;
        rdata_o = '0;
        if (resp_q.vld) begin
            vld_o[resp_sel] = 1'b1;
            if (resp_q.is_read) begin
                rdata_o[resp_sel] = mem_rdata_i;
            end
        end
    end

`ifdef TCDM_BANK_ARB_PERF_EN
    logic [31:0] perf_q;
    logic        conflict;

    assign conflict = ($countones(req_i) > 1);

    // Saturating count of cycles where two or more masters competed for the bank
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (conflict && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_conf_o = perf_q;
`else
    assign perf_conf_o = 32'h0;
`endif

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// tb/tb_tcdm_bank_arbiter.sv - directed self-checking bench for tcdm_bank_arbiter
module tb_tcdm_bank_arbiter;

    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req;
    logic [N-1:0][31:0]    add;
    logic [N-1:0]          wen;
    logic [N-1:0][31:0]    wdata;
    logic [N-1:0][3:0]     be;
    logic [N-1:0]          gnt;
    logic [N-1:0]          vld;
    logic [N-1:0][31:0]    rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [9:0]            mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_be;
    logic [31:0]           mem_rdata;
    logic [31:0]           perf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0]   mem [1024];
    logic [1023:0] written;

    always #5 clk = ~clk;

    tcdm_bank_arbiter #(
        .NumReq      (N),
        .AddrWidth   (32),
        .DataWidth   (32),
        .BankAddrW   (10),
        .WriteRespOn (1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .add_i       (add),
        .wen_i       (wen),
        .wdata_i     (wdata),
        .be_i        (be),
        .gnt_o       (gnt),
        .vld_o       (vld),
        .rdata_o     (rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rdata_i (mem_rdata),
        .perf_conf_o (perf)
    );

    function automatic logic [31:0] pat(input logic [9:0] a);
        return 32'hA500_0000 | {22'h0, a};
    endfunction

    // Single-port SRAM with 1-cycle read latency; unwritten words read a known pattern
    always @(posedge clk) begin
        logic [31:0] cur;
        if (rst) begin
            written <= '0;
        end else if (mem_req) begin
            cur = written[mem_addr] ? mem[mem_addr] : pat(mem_addr);
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                end
                mem[mem_addr]     <= cur;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= cur;
            end
        end
    end

    task automatic clear_reqs();
        req   = '0;
        wen   = '0;
        add   = '0;
        wdata = '0;
        be    = '0;
    endtask

    task automatic set_m(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        req[i]   = 1'b1;
        wen[i]   = w;
        add[i]   = a;
        wdata[i] = d;
        be[i]    = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_m(0, 1'b1, 32'h0, 32'h0, 4'hF);
        @(negedge clk);
        total_cnt++;
        if (gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b want %b", gnt, 4'b0001);
        else pass_cnt++;
        step();
        rst = 1'b1;
        clear_reqs();
        #1;
        total_cnt++;
        if (vld !== 4'b0000) $display("FAIL reset_vld_during: got %b want %b", vld, 4'b0000);
        else pass_cnt++;
        total_cnt++;
        if (perf !== 32'h0) $display("FAIL reset_perf: got %h want %h", perf, 32'h0);
        else pass_cnt++;
        step();
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (vld !== 4'b0000) $display("FAIL reset_vld_after: got %b want %b", vld, 4'b0000);
        else pass_cnt++;
        step();
        for (int i = 0; i < N; i++) set_m(i, 1'b1, 32'h0, 32'h0, 4'hF);
        @(negedge clk);
        total_cnt++;
        if (gnt !== 4'b0001) $display("FAIL reset_ptr_zero: got %b want %b", gnt, 4'b0001);
        else pass_cnt++;
        step();
        clear_reqs();
        set_m(2, 1'b1, 32'h0, 32'h0, 4'hF);
        @(negedge clk);
        total_cnt++;
        if (gnt !== 4'b0100) $display("FAIL reset_lone_gnt: got %b want %b", gnt, 4'b0100);
        else pass_cnt++;
        step();
        clear_reqs();
    endtask

    task automatic test_write_read();
        do_reset();
        set_m(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        total_cnt++;
        if ({gnt, mem_req, mem_we, mem_addr, mem_be} !== {4'b0001, 1'b1, 1'b1, 10'd4, 4'hF})
            $display("FAIL wr_bank_cmd: got gnt=%b req=%b we=%b addr=%0d be=%h want 0001 1 1 4 f",
                     gnt, mem_req, mem_we, mem_addr, mem_be);
        else pass_cnt++;
        total_cnt++;
        if (mem_wdata !== 32'hDEADBEEF) $display("FAIL wr_wdata: got %h want %h", mem_wdata, 32'hDEADBEEF);
        else pass_cnt++;
        step();
        clear_reqs();
        set_m(0, 1'b1, 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        total_cnt++;
        if ({mem_we, mem_addr} !== {1'b0, 10'd4})
            $display("FAIL rd_bank_cmd: got we=%b addr=%0d want 0 4", mem_we, mem_addr);
        else pass_cnt++;
        total_cnt++;
        if (vld !== 4'b0001 || rdata[0] !== 32'h0)
            $display("FAIL wr_resp: got vld=%b rdata0=%h want 0001 00000000", vld, rdata[0]);
        else pass_cnt++;
        step();
        clear_reqs();
        @(negedge clk);
        total_cnt++;
        if (vld !== 4'b0001 || rdata[0] !== 32'hDEADBEEF)
            $display("FAIL rd_resp: got vld=%b rdata0=%h want 0001 deadbeef", vld, rdata[0]);
        else pass_cnt++;
        step();
    endtask

    task automatic test_fairness();
        logic [3:0] expg;
        logic [3:0] expv;
        int         p;
        do_reset();
        for (int i = 0; i < N; i++) set_m(i, 1'b1, 32'h100 + 32'(4 * i), 32'h0, 4'hF);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            expg = 4'(1 << (k % 4));
            total_cnt++;
            if (gnt !== expg) $display("FAIL fair_gnt_%0d: got %b want %b", k, gnt, expg);
            else pass_cnt++;
            if (k > 0) begin
                p    = (k - 1) % 4;
                expv = 4'(1 << p);
                total_cnt++;
                if (vld !== expv || rdata[p] !== pat(10'(10'h40 + p)))
                    $display("FAIL fair_vld_%0d: got vld=%b rdata=%h want %b %h",
                             k, vld, rdata[p], expv, pat(10'(10'h40 + p)));
                else pass_cnt++;
            end
            step();
        end
        clear_reqs();
        @(negedge clk);
        total_cnt++;
        if (vld !== 4'b1000 || rdata[3] !== pat(10'h43))
            $display("FAIL fair_last_vld: got vld=%b rdata3=%h want 1000 %h", vld, rdata[3], pat(10'h43));
        else pass_cnt++;
        total_cnt++;
        if ({gnt, mem_req, mem_addr} !== {4'b0000, 1'b0, 10'd0})
            $display("FAIL idle_bank: got gnt=%b req=%b addr=%0d want 0000 0 0", gnt, mem_req, mem_addr);
        else pass_cnt++;
        step();
    endtask

    task automatic test_wrap_skip();
        do_reset();
        set_m(2, 1'b1, 32'h0, 32'h0, 4'hF);
        step();
        clear_reqs();
        set_m(0, 1'b1, 32'h0, 32'h0, 4'hF);
        set_m(2, 1'b1, 32'h8, 32'h0, 4'hF);
        @(negedge clk);
        total_cnt++;
        if (gnt !== 4'b0001) $display("FAIL wrap_gnt0: got %b want %b", gnt, 4'b0001);
        else pass_cnt++;
        step();
        @(negedge clk);
        total_cnt++;
        if (gnt !== 4'b0100) $display("FAIL skip_gnt2: got %b want %b", gnt, 4'b0100);
        else pass_cnt++;
        step();
        @(negedge clk);
        total_cnt++;
        if (gnt !== 4'b0001) $display("FAIL ptr3_gnt0: got %b want %b", gnt, 4'b0001);
        else pass_cnt++;
        step();
        clear_reqs();
    endtask

    task automatic test_byte_enables();
        do_reset();
        set_m(1, 1'b0, 32'h20, 32'hAABBCCDD, 4'hF);
        step();
        clear_reqs();
        set_m(1, 1'b0, 32'h20, 32'h11223344, 4'b0011);
        @(negedge clk);
        total_cnt++;
        if (mem_be !== 4'b0011) $display("FAIL be_lanes: got %b want %b", mem_be, 4'b0011);
        else pass_cnt++;
        step();
        clear_reqs();
        set_m(1, 1'b1, 32'h1023, 32'h0, 4'hF);
        @(negedge clk);
        total_cnt++;
        if ({mem_we, mem_addr} !== {1'b0, 10'd8})
            $display("FAIL addr_wrap: got we=%b addr=%0d want 0 8", mem_we, mem_addr);
        else pass_cnt++;
        step();
        clear_reqs();
        @(negedge clk);
        total_cnt++;
        if (vld !== 4'b0010 || rdata[1] !== 32'hAABB3344 || rdata[0] !== 32'h0)
            $display("FAIL be_readback: got vld=%b rdata1=%h rdata0=%h want 0010 aabb3344 00000000",
                     vld, rdata[1], rdata[0]);
        else pass_cnt++;
        step();
    endtask

    task automatic test_perf();
        logic [31:0] exp_perf;
`ifdef TCDM_BANK_ARB_PERF_EN
        exp_perf = 32'd5;
`else
        exp_perf = 32'd0;
`endif
        do_reset();
        set_m(0, 1'b1, 32'h0, 32'h0, 4'hF);
        set_m(1, 1'b1, 32'h4, 32'h0, 4'hF);
        for (int k = 0; k < 5; k++) step();
        clear_reqs();
        set_m(0, 1'b1, 32'h0, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) step();
        clear_reqs();
        @(negedge clk);
        total_cnt++;
        if (perf !== exp_perf) $display("FAIL perf_count: got %0d want %0d", perf, exp_perf);
        else pass_cnt++;
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        test_reset();
        test_write_read();
        test_fairness();
        test_wrap_skip();
        test_byte_enables();
        test_perf();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
